decod_scan_seq: RTL and testbench

- Scan sequencer that sits directly upstream of the 4-to-16 one-hot decoder and drives its five inputs a, b, c, d, e.
- Walks the 16 decoder outputs (f..u) in order, skipping slots masked off, and holds each selected output high for a programmable dwell time.
- Changes the code only while e=0 (break-before-make), so the decoder never shows two hot outputs or a glitch between slots.

---
 rtl/decod_scan_seq_if.sv | 26 ++
 rtl/decod_scan_seq.sv | 137 +++++++++++++
 tb/tb_decod_scan_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decod_scan_seq_if.sv
// Control and decoder-drive bundle between the scan sequencer and whatever controls it.
// The sequencer takes the slave modport and the controller takes the master modport.
interface decod_scan_seq_if;
    logic        start;
    logic        cont;
    logic        stop;
    logic [15:0] mask;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        e;
    logic [3:0]  slot;
    logic        busy;
    logic        done;

    modport master (
        output start, cont, stop, mask,
        input  a, b, c, d, e, slot, busy, done
    );

    modport slave (
        input  start, cont, stop, mask,
        output a, b, c, d, e, slot, busy, done
    );
endinterface

// File: rtl/decod_scan_seq.sv
// Scan sequencer feeding a 4-to-16 one-hot decoder: steps through enabled slots in ascending
// order and holds the decoder enable for DWELL cycles per slot, changing the code only while e=0.
module decod_scan_seq #(
    parameter int DWELL   = 4,
    parameter int DWELL_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    decod_scan_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_n;
    logic [3:0]           slot_q, slot_n;
    logic [3:0]           code_q;
    logic [DWELL_W-1:0]   cnt_q, cnt_n;
    logic [15:0]          mask_q, mask_n;
    logic                 cont_q, cont_n;
    logic                 e_q, busy_q, done_q;
    logic [4:0]           first_hit;
    logic [4:0]           next_hit;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [4:0] pick(input logic [15:0] m, input logic [4:0] from);
        logic [4:0] r;
        r = '0;
        for (int k = 15; k >= 0; k--) begin
            if (m[k] && (k >= int'(from))) begin
                r = {1'b1, k[3:0]};
            end
        end
        return r;
    endfunction

    always_comb begin
        first_hit = pick(bus.mask, 5'd0);
        next_hit  = pick(mask_q, {1'b0, slot_q} + 5'd1);
    end

    always_comb begin
        state_n = state_q;
        slot_n  = slot_q;
        cnt_n   = cnt_q;
        mask_n  = mask_q;
        cont_n  = cont_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    mask_n = bus.mask;
                    cont_n = bus.cont;
                    if (first_hit[4]) begin
                        state_n = SETUP;
                        slot_n  = first_hit[3:0];
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SETUP: begin
                if (bus.stop) begin
                    state_n = IDLE;
                end else begin
                    state_n = DRIVE;
                    cnt_n   = DWELL_W'(DWELL - 1);
                end
            end
            DRIVE: begin
                if (bus.stop) begin
                    state_n = IDLE;
                end else if (cnt_q == '0) begin
                    if (next_hit[4]) begin
                        state_n = SETUP;
                        slot_n  = next_hit[3:0];
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                if (cont_q && !bus.stop) begin
                    mask_n = bus.mask;
                    if (first_hit[4]) begin
                        state_n = SETUP;
                        slot_n  = first_hit[3:0];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so e, busy and done line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            slot_q  <= slot_n;
            cnt_q   <= cnt_n;
            mask_q  <= mask_n;
            cont_q  <= cont_n;
            if (state_n == SETUP) begin
                code_q <= 4'hF - slot_n;
            end
            e_q     <= (state_n == DRIVE);
            busy_q  <= (state_n == SETUP) || (state_n == DRIVE);
            done_q  <= (state_n == DONE);
        end
    end

    assign bus.a    = code_q[3];
    assign bus.b    = code_q[2];
    assign bus.c    = code_q[1];
    assign bus.d    = code_q[0];
    assign bus.e    = e_q;
    assign bus.slot = slot_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_decod_scan_seq.sv
// Directed testbench for decod_scan_seq: one DUT with DWELL=4 and one with DWELL=1,
// observed as {code, e, slot, busy, done} and compared against hand-computed vectors.
module tb_decod_scan_seq;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    decod_scan_seq_if bus4 ();
    decod_scan_seq_if bus1 ();

    decod_scan_seq #(.DWELL(4), .DWELL_W(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    decod_scan_seq #(.DWELL(1), .DWELL_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic [10:0] obs4;
    logic [10:0] obs1;
    assign obs4 = {bus4.a, bus4.b, bus4.c, bus4.d, bus4.e, bus4.slot, bus4.busy, bus4.done};
    assign obs1 = {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e, bus1.slot, bus1.busy, bus1.done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ev(input logic [3:0] code, input logic e,
                                       input logic [3:0] slot, input logic busy,
                                       input logic done);
        return {code, e, slot, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus4.start = 1'b0; bus4.cont = 1'b0; bus4.stop = 1'b0; bus4.mask = '0;
        bus1.start = 1'b0; bus1.cont = 1'b0; bus1.stop = 1'b0; bus1.mask = '0;
        #12;
        checks++;
        if (obs4 !== ev(4'h0, 0, 4'd0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL reset_dut4: got %h expected %h", obs4, ev(4'h0, 0, 4'd0, 0, 0));
        end
        checks++;
        if (obs1 !== ev(4'h0, 0, 4'd0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got %h expected %h", obs1, ev(4'h0, 0, 4'd0, 0, 0));
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (obs4 !== ev(4'h0, 0, 4'd0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %h expected %h", obs4, ev(4'h0, 0, 4'd0, 0, 0));
        end
    endtask

    task automatic test_full_scan();
        logic [10:0] exp;
        bus4.mask  = 16'hFFFF;
        bus4.cont  = 1'b0;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp = ev(4'(15 - k), 0, 4'(k), 1, 0);
            checks++;
            if (obs4 !== exp) begin
                errors++;
                $display("[TB] FAIL full_setup_%0d: got %h expected %h", k, obs4, exp);
            end
            for (int j = 0; j < 4; j++) begin
                if (k == 7 && j == 1) bus4.start = 1'b1;
                tick();
                bus4.start = 1'b0;
                exp = ev(4'(15 - k), 1, 4'(k), 1, 0);
                checks++;
                if (obs4 !== exp) begin
                    errors++;
                    $display("[TB] FAIL full_drive_%0d_%0d: got %h expected %h", k, j, obs4, exp);
                end
            end
            tick();
        end
        checks++;
        if (obs4 !== ev(4'h0, 0, 4'd15, 0, 1)) begin
            errors++;
            $display("[TB] FAIL full_done: got %h expected %h", obs4, ev(4'h0, 0, 4'd15, 0, 1));
        end
        tick();
        checks++;
        if (obs4 !== ev(4'h0, 0, 4'd15, 0, 0)) begin
            errors++;
            $display("[TB] FAIL full_idle: got %h expected %h", obs4, ev(4'h0, 0, 4'd15, 0, 0));
        end
    endtask

    task automatic test_sparse_dwell1();
        logic [10:0] tbl [6];
        tbl[0] = ev(4'hF, 0, 4'd0,  1, 0);
        tbl[1] = ev(4'hF, 1, 4'd0,  1, 0);
        tbl[2] = ev(4'h0, 0, 4'd15, 1, 0);
        tbl[3] = ev(4'h0, 1, 4'd15, 1, 0);
        tbl[4] = ev(4'h0, 0, 4'd15, 0, 1);
        tbl[5] = ev(4'h0, 0, 4'd15, 0, 0);
        bus1.mask  = 16'h8001;
        bus1.cont  = 1'b0;
        bus1.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus1.start = 1'b0;
            checks++;
            if (obs1 !== tbl[i]) begin
                errors++;
                $display("[TB] FAIL sparse_cycle_%0d: got %h expected %h", i + 1, obs1, tbl[i]);
            end
        end
    endtask

    task automatic test_empty_mask();
        for (int m = 0; m < 2; m++) begin
            bus4.mask  = 16'h0000;
            bus4.cont  = (m == 1);
            bus4.start = 1'b1;
            tick();
            bus4.start = 1'b0;
            checks++;
            if (obs4 !== ev(4'h0, 0, 4'd15, 0, 1)) begin
                errors++;
                $display("[TB] FAIL empty_done_cont%0d: got %h expected %h", m, obs4, ev(4'h0, 0, 4'd15, 0, 1));
            end
            tick();
            tick();
            checks++;
            if (obs4 !== ev(4'h0, 0, 4'd15, 0, 0)) begin
                errors++;
                $display("[TB] FAIL empty_idle_cont%0d: got %h expected %h", m, obs4, ev(4'h0, 0, 4'd15, 0, 0));
            end
        end
        bus4.cont = 1'b0;
    endtask

    task automatic test_continuous();
        logic [10:0] tbl [11];
        tbl[0]  = ev(4'hB, 0, 4'd4, 1, 0);
        tbl[1]  = ev(4'hB, 1, 4'd4, 1, 0);
        tbl[2]  = ev(4'hB, 1, 4'd4, 1, 0);
        tbl[3]  = ev(4'hB, 1, 4'd4, 1, 0);
        tbl[4]  = ev(4'hB, 1, 4'd4, 1, 0);
        tbl[5]  = ev(4'hB, 0, 4'd4, 0, 1);
        tbl[6]  = ev(4'hA, 0, 4'd5, 1, 0);
        tbl[7]  = ev(4'hA, 1, 4'd5, 1, 0);
        tbl[8]  = ev(4'hA, 1, 4'd5, 1, 0);
        tbl[9]  = ev(4'hA, 0, 4'd5, 0, 0);
        tbl[10] = ev(4'hA, 0, 4'd5, 0, 0);
        bus4.mask  = 16'h0010;
        bus4.cont  = 1'b1;
        bus4.start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            bus4.start = 1'b0;
            bus4.cont  = 1'b0;
            if (i == 0) bus4.mask = 16'h0020;
            bus4.stop = (i == 8);
            checks++;
            if (obs4 !== tbl[i]) begin
                errors++;
                $display("[TB] FAIL cont_cycle_%0d: got %h expected %h", i + 1, obs4, tbl[i]);
            end
        end
        bus4.stop = 1'b0;
    endtask

    task automatic test_stop();
        logic [10:0] tbl [5];
        tbl[0] = ev(4'hC, 0, 4'd3, 1, 0);
        tbl[1] = ev(4'hC, 1, 4'd3, 1, 0);
        tbl[2] = ev(4'hC, 1, 4'd3, 1, 0);
        tbl[3] = ev(4'hC, 0, 4'd3, 0, 0);
        tbl[4] = ev(4'hC, 0, 4'd3, 0, 0);
        bus4.mask  = 16'h0008;
        bus4.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus4.start = 1'b0;
            bus4.stop  = (i == 2);
            checks++;
            if (obs4 !== tbl[i]) begin
                errors++;
                $display("[TB] FAIL stop_cycle_%0d: got %h expected %h", i + 1, obs4, tbl[i]);
            end
        end
        bus4.mask  = 16'hFFFF;
        bus4.start = 1'b1;
        bus4.stop  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus4.start = 1'b0;
            bus4.stop  = 1'b0;
            checks++;
            if (obs4 !== ev(4'hC, 0, 4'd3, 0, 0)) begin
                errors++;
                $display("[TB] FAIL start_stop_idle_%0d: got %h expected %h", i, obs4, ev(4'hC, 0, 4'd3, 0, 0));
            end
        end
    endtask

    task automatic test_async_reset();
        bus4.mask  = 16'h0004;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        tick();
        checks++;
        if (obs4 !== ev(4'hD, 1, 4'd2, 1, 0)) begin
            errors++;
            $display("[TB] FAIL pre_reset_drive: got %h expected %h", obs4, ev(4'hD, 1, 4'd2, 1, 0));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs4 !== ev(4'h0, 0, 4'd0, 0, 0)) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", obs4, ev(4'h0, 0, 4'd0, 0, 0));
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs4 !== ev(4'h0, 0, 4'd0, 0, 0)) begin
                errors++;
                $display("[TB] FAIL post_reset_idle_%0d: got %h expected %h", i, obs4, ev(4'h0, 0, 4'd0, 0, 0));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_full_scan();
        test_sparse_dwell1();
        test_empty_mask();
        test_continuous();
        test_stop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
